// File: rtl/shift_seq_if.sv
// Operand/result bundle between the instruction sequencer and shift_seq.
// The master issues the operation and the slave returns the status and result.
interface shift_seq_if #(parameter int CW = 4);
  logic          start;
  logic [7:0]    din;
  logic          cin;
  logic [2:0]    mode;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic [7:0]    dout;
  logic          cout;
  logic          zero;

  modport master (
    output start, din, cin, mode, count,
    input  busy, done, dout, cout, zero
  );

  modport slave (
    input  start, din, cin, mode, count,
    output busy, done, dout, cout, zero
  );
endinterface

// File: rtl/shift_seq.sv
// Multi-step shift sequencer: iterates a one-bit shift unit once per clock,
// then presents the final value, carry and zero flag with a one-cycle done pulse.

module shift (
  input  logic [7:0] din,
  input  logic       cin,
  input  logic [2:0] mode,
  output logic [7:0] dout,
  output logic       cout
);
  always_comb begin
    dout = din;
    cout = 1'b0;
    case (mode)
      3'b000: begin dout = {din[6:0], 1'b0};   cout = din[7]; end
      3'b001: begin dout = {din[6:0], cin};    cout = din[7]; end
      3'b010: begin dout = {din[6:0], din[0]}; cout = din[7]; end
      3'b011: begin dout = {din[6:0], din[7]}; cout = din[7]; end
      3'b100: begin dout = {1'b0, din[7:1]};   cout = din[0]; end
      3'b101: begin dout = {cin, din[7:1]};    cout = din[0]; end
      3'b110: begin dout = {din[0], din[7:1]}; cout = din[0]; end
      default: begin dout = {din[7], din[7:1]}; cout = din[0]; end
    endcase
  end
endmodule

module shift_seq #(
  parameter int CW = 4
) (
  input logic        clk,
  input logic        rst_n,
  shift_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [7:0]    acc;
  logic          carry;
  logic [2:0]    mreg;
  logic [CW-1:0] rem;
  logic [7:0]    sh_out;
  logic          sh_cout;
  logic          load_out;
  logic [7:0]    out_acc;
  logic          out_carry;
  logic [7:0]    dout_r;
  logic          cout_r;
  logic          zero_r;

  shift u_shift (
    .din  (acc),
    .cin  (carry),
    .mode (mreg),
    .dout (sh_out),
    .cout (sh_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A zero count completes straight from IDLE with the operand itself as the result.
  always_comb begin
    state_next = state;
    load_out   = 1'b0;
    out_acc    = acc;
    out_carry  = carry;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.count == '0) begin
            state_next = DONE;
            load_out   = 1'b1;
            out_acc    = bus.din;
            out_carry  = bus.cin;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (rem <= CW'(1)) begin
          state_next = DONE;
          load_out   = 1'b1;
          out_acc    = sh_out;
          out_carry  = sh_cout;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= 8'h00;
      carry <= 1'b0;
      mreg  <= 3'b000;
      rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc   <= bus.din;
            carry <= bus.cin;
            mreg  <= bus.mode;
            rem   <= bus.count;
          end
        end
        RUN: begin
          acc   <= sh_out;
          carry <= sh_cout;
          if (rem != '0) rem <= rem - CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers only move on entry to DONE, so they hold through RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r <= 8'h00;
      cout_r <= 1'b0;
      zero_r <= 1'b1;
    end else if (load_out) begin
      dout_r <= out_acc;
      cout_r <= out_carry;
      zero_r <= (out_acc == 8'h00);
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.dout = dout_r;
  assign bus.cout = cout_r;
  assign bus.zero = zero_r;
endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq: a table of operations with hand-computed
// results, plus hand-written sequences for ignored start and mid-run reset.
module tb_shift_seq;
  typedef struct {
    logic [2:0] mode;
    logic [7:0] din;
    logic       cin;
    logic [3:0] count;
    logic [7:0] exp_dout;
    logic       exp_cout;
    logic       exp_zero;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   errors;
  vec_t vecs[11];

  shift_seq_if #(.CW(4)) bus ();

  shift_seq #(.CW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Launches one operation, scrambles the inputs after acceptance and
  // follows it to completion, checking latency, busy and result stability.
  task automatic apply_stimulus(input vec_t v);
    logic [7:0] prev;
    logic       stable;
    logic       busy_ok;
    int         cyc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.din   = v.din;
    bus.cin   = v.cin;
    bus.mode  = v.mode;
    bus.count = v.count;
    @(negedge clk);
    bus.start = 1'b0;
    bus.din   = ~v.din;
    bus.cin   = ~v.cin;
    bus.mode  = v.mode ^ 3'b101;
    bus.count = ~v.count;
    prev    = bus.dout;
    stable  = 1'b1;
    busy_ok = 1'b1;
    cyc     = 1;
    while (!bus.done && cyc < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.dout !== prev) stable = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check_output("done_latency", cyc, 32'(v.count) + 1);
    check_output("busy_in_run", busy_ok, 1);
    check_output("dout_stable_in_run", stable, 1);
    check_output("busy_in_done", bus.busy, 1);
    check_output("dout", bus.dout, v.exp_dout);
    check_output("cout", bus.cout, v.exp_cout);
    check_output("zero", bus.zero, v.exp_zero);
    @(negedge clk);
    check_output("done_pulse_end", bus.done, 0);
    check_output("busy_end", bus.busy, 0);
  endtask

  initial begin
    logic seen_done;
    tests  = 0;
    errors = 0;
    vecs[0]  = '{3'b000, 8'h01, 1'b0, 4'd3,  8'h08, 1'b0, 1'b0};
    vecs[1]  = '{3'b101, 8'h01, 1'b0, 4'd2,  8'h80, 1'b0, 1'b0};
    vecs[2]  = '{3'b111, 8'h80, 1'b0, 4'd7,  8'hFF, 1'b0, 1'b0};
    vecs[3]  = '{3'b000, 8'h80, 1'b0, 4'd1,  8'h00, 1'b1, 1'b1};
    vecs[4]  = '{3'b011, 8'h5A, 1'b1, 4'd0,  8'h5A, 1'b1, 1'b0};
    vecs[5]  = '{3'b011, 8'h81, 1'b0, 4'd15, 8'hC0, 1'b0, 1'b0};
    vecs[6]  = '{3'b001, 8'h80, 1'b1, 4'd1,  8'h01, 1'b1, 1'b0};
    vecs[7]  = '{3'b100, 8'h03, 1'b0, 4'd1,  8'h01, 1'b1, 1'b0};
    vecs[8]  = '{3'b110, 8'h01, 1'b0, 4'd1,  8'h80, 1'b1, 1'b0};
    vecs[9]  = '{3'b001, 8'h80, 1'b0, 4'd9,  8'h80, 1'b0, 1'b0};
    vecs[10] = '{3'b100, 8'hFF, 1'b0, 4'd8,  8'h00, 1'b1, 1'b1};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.din   = 8'h00;
    bus.cin   = 1'b0;
    bus.mode  = 3'b000;
    bus.count = 4'd0;
    repeat (2) @(negedge clk);
    check_output("rst_busy", bus.busy, 0);
    check_output("rst_done", bus.done, 0);
    check_output("rst_dout", bus.dout, 8'h00);
    check_output("rst_cout", bus.cout, 0);
    check_output("rst_zero", bus.zero, 1);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) apply_stimulus(vecs[i]);

    // Zero-count op, with a second start held through its DONE cycle.
    @(negedge clk);
    bus.start = 1'b1;
    bus.din   = 8'h5A;
    bus.cin   = 1'b1;
    bus.mode  = 3'b011;
    bus.count = 4'd0;
    @(negedge clk);
    check_output("zc_done", bus.done, 1);
    check_output("zc_dout", bus.dout, 8'h5A);
    check_output("zc_cout", bus.cout, 1);
    bus.din = 8'hFF;
    bus.cin = 1'b0;
    @(negedge clk);
    check_output("ign_done", bus.done, 0);
    check_output("ign_busy", bus.busy, 0);
    check_output("ign_dout", bus.dout, 8'h5A);
    @(negedge clk);
    bus.start = 1'b0;
    check_output("next_done", bus.done, 1);
    check_output("next_dout", bus.dout, 8'hFF);
    check_output("next_cout", bus.cout, 0);
    @(negedge clk);

    // Reset during cycle 2 of a five-step run.
    bus.start = 1'b1;
    bus.din   = 8'h03;
    bus.cin   = 1'b0;
    bus.mode  = 3'b000;
    bus.count = 4'd5;
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("mid_rst_busy", bus.busy, 0);
    check_output("mid_rst_done", bus.done, 0);
    check_output("mid_rst_dout", bus.dout, 8'h00);
    check_output("mid_rst_cout", bus.cout, 0);
    check_output("mid_rst_zero", bus.zero, 1);
    @(negedge clk);
    rst_n     = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    check_output("no_done_after_rst", seen_done, 0);
    apply_stimulus('{3'b000, 8'h03, 1'b0, 4'd1, 8'h06, 1'b0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
